// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ALIGN = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned FRAME_W        = 11;
  localparam int unsigned FRAME_LEN_BASE = 10;
  localparam int unsigned FRAME_LEN_PAR  = 11;

  // 2'b11 is treated as no parity, same as PAR_NONE.
  function automatic logic parity_en(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a request, hands the config to the framer,
// then serialises the framed character LSB first, one bit per baud tick.
module uart_tx_ctrl #(
  parameter int unsigned FRAME_W = uart_pkg::FRAME_W,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_start,
  input  logic [7:0]         data_in,
  input  logic [1:0]         parity_type,
  input  logic               data_length,
  input  logic               stop_bits,
  input  logic               baud_tick,
  input  logic [FRAME_W-1:0] frame_in,
  output logic [7:0]         fr_data,
  output logic [1:0]         fr_parity_type,
  output logic               fr_data_length,
  output logic               fr_stop_bits,
  output logic               tx_active,
  output logic               tx_out,
  output logic               ready,
  output logic               done,
  output logic               cfg_err
);
  import uart_pkg::*;

  localparam logic [CNT_W-1:0] LAST_BASE = CNT_W'(FRAME_LEN_BASE - 1);
  localparam logic [CNT_W-1:0] LAST_PAR  = CNT_W'(FRAME_LEN_PAR - 1);

  tx_state_e          state, state_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]   last_idx, last_idx_nxt;
  logic               accept, reject;
  logic               tx_out_nxt, ready_nxt, done_nxt, tx_active_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    last_idx_nxt = last_idx;
    accept       = 1'b0;
    reject       = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          accept = 1'b1;
          if (data_length != stop_bits) state_nxt = LOAD;
          else                          reject    = 1'b1;
        end
      end
      LOAD: begin
        shreg_nxt    = frame_in;
        bit_cnt_nxt  = '0;
        last_idx_nxt = parity_en(fr_parity_type) ? LAST_PAR : LAST_BASE;
        state_nxt    = ALIGN;
      end
      ALIGN: begin
        if (baud_tick) state_nxt = SEND;
      end
      SEND: begin
        if (baud_tick) begin
          // Counter stops at the last index, so it never wraps.
          if (bit_cnt == last_idx) begin
            state_nxt = DONE;
          end else begin
            shreg_nxt   = {1'b1, shreg[FRAME_W-1:1]};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    tx_out_nxt    = (state_nxt == SEND) ? shreg_nxt[0] : 1'b1;
    ready_nxt     = (state_nxt == IDLE);
    done_nxt      = (state_nxt == DONE);
    tx_active_nxt = (state_nxt == LOAD) || (state_nxt == ALIGN) || (state_nxt == SEND);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg          <= '1;
      bit_cnt        <= '0;
      last_idx       <= LAST_BASE;
      fr_data        <= '0;
      fr_parity_type <= '0;
      fr_data_length <= 1'b0;
      fr_stop_bits   <= 1'b0;
      tx_out         <= 1'b1;
      ready          <= 1'b1;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
      tx_active      <= 1'b0;
    end else begin
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      last_idx <= last_idx_nxt;
      if (accept) begin
        fr_data        <= data_in;
        fr_parity_type <= parity_type;
        fr_data_length <= data_length;
        fr_stop_bits   <= stop_bits;
      end
      tx_out    <= tx_out_nxt;
      ready     <= ready_nxt;
      done      <= done_nxt;
      cfg_err   <= reject;
      tx_active <= tx_active_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural framer and a 16-cycle baud tick.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [7:0]  data_in = '0;
  logic [1:0]  parity_type = '0;
  logic        data_length = 1'b0;
  logic        stop_bits = 1'b0;
  logic        baud_tick;
  logic [10:0] frame_in;
  logic [7:0]  fr_data;
  logic [1:0]  fr_parity_type;
  logic        fr_data_length, fr_stop_bits;
  logic        tx_active, tx_out, ready, done, cfg_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] tick_cnt = '0;

  uart_tx_ctrl dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in),
    .parity_type(parity_type), .data_length(data_length), .stop_bits(stop_bits),
    .baud_tick(baud_tick), .frame_in(frame_in), .fr_data(fr_data),
    .fr_parity_type(fr_parity_type), .fr_data_length(fr_data_length),
    .fr_stop_bits(fr_stop_bits), .tx_active(tx_active), .tx_out(tx_out),
    .ready(ready), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Free-running baud strobe, one cycle in sixteen
  always @(posedge clk) tick_cnt <= tick_cnt + 4'd1;
  assign baud_tick = (tick_cnt == 4'd15);

  // Behavioural framer: start, data LSB first, optional parity, stop bits as 1s
  function automatic logic [10:0] build_frame(input logic [7:0] d, input logic [1:0] pt,
                                              input logic dl);
    logic [10:0] f;
    logic        p;
    int          nd;
    f  = '1;
    f[0] = 1'b0;
    nd = dl ? 8 : 7;
    for (int i = 0; i < 8; i++) if (i < nd) f[1+i] = d[i];
    p = dl ? ^d : ^d[6:0];
    if (pt == 2'b01) f[1+nd] = ~p;
    else if (pt == 2'b10) f[1+nd] = p;
    return f;
  endfunction

  always_comb frame_in = build_frame(fr_data, fr_parity_type, fr_data_length);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", ready, 1);
  endtask

  // Called at the first LOAD negedge; ends at the IDLE negedge after DONE.
  task automatic check_frame(input string tag, input logic [10:0] bits, input int n,
                             input int wait_exp);
    int   w;
    int   bad;
    logic prev_tick;
    chk({tag, "_load_active"}, tx_active, 1);
    chk({tag, "_load_ready"}, ready, 0);
    chk({tag, "_load_line"}, tx_out, 1);
    w = 0;
    prev_tick = 1'b0;
    do begin
      prev_tick = baud_tick;
      @(negedge clk);
      w++;
    end while (tx_out !== 1'b0 && w < 64);
    chk({tag, "_start_bit_seen"}, tx_out, 0);
    if (tx_out !== 1'b0) return;
    chk({tag, "_align_on_tick"}, prev_tick, 1);
    if (wait_exp >= 0) chk({tag, "_align_wait"}, w, wait_exp);
    for (int i = 0; i < n; i++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        if (tx_out !== bits[i] || tx_active !== 1'b1) bad++;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, i), bad, 0);
    end
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_done_line"}, tx_out, 1);
    chk({tag, "_done_inactive"}, tx_active, 0);
    @(negedge clk);
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_idle_ready"}, ready, 1);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  ptype;
    logic        dlen;
    logic        sbits;
    int          nbits;   // 0 marks an illegal configuration
    logic [10:0] bits;    // expected line bits, bit 0 first on the wire
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bad;

    vecs[0] = '{8'hA5, 2'b10, 1'b1, 1'b0, 11, 11'b10101001010};
    vecs[1] = '{8'h41, 2'b00, 1'b0, 1'b1, 10, 11'b11110000010};
    vecs[2] = '{8'h3C, 2'b01, 1'b1, 1'b0, 11, 11'b11001111000};
    vecs[3] = '{8'hD3, 2'b10, 1'b0, 1'b1, 11, 11'b11010100110};
    vecs[4] = '{8'h00, 2'b11, 1'b1, 1'b0, 10, 11'b11000000000};
    vecs[5] = '{8'h5A, 2'b01, 1'b1, 1'b1, 0,  11'b11111111111};
    vecs[6] = '{8'h77, 2'b00, 1'b0, 1'b0, 0,  11'b11111111111};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_ready", ready, 1);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_fr", {fr_data, fr_parity_type, fr_data_length, fr_stop_bits}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames and illegal configurations
    for (int v = 0; v < 7; v++) begin
      wait_ready();
      data_in     = vecs[v].data;
      parity_type = vecs[v].ptype;
      data_length = vecs[v].dlen;
      stop_bits   = vecs[v].sbits;
      tx_start    = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      chk($sformatf("v%0d_fr", v), {fr_data, fr_parity_type, fr_data_length, fr_stop_bits},
          {vecs[v].data, vecs[v].ptype, vecs[v].dlen, vecs[v].sbits});
      if (vecs[v].nbits != 0) begin
        check_frame($sformatf("v%0d", v), vecs[v].bits, vecs[v].nbits, -1);
      end else begin
        chk($sformatf("v%0d_cfg_err", v), cfg_err, 1);
        chk($sformatf("v%0d_err_inactive", v), tx_active, 0);
        chk($sformatf("v%0d_err_line", v), tx_out, 1);
        chk($sformatf("v%0d_err_ready", v), ready, 1);
        @(negedge clk);
        chk($sformatf("v%0d_cfg_err_clear", v), cfg_err, 0);
        chk($sformatf("v%0d_err_inactive2", v), tx_active, 0);
      end
    end

    // Request coincident with a baud tick in IDLE
    begin
      int k = 0;
      while (baud_tick !== 1'b1 && k < 32) begin
        @(negedge clk);
        k++;
      end
      chk("coinc_tick_found", baud_tick, 1);
      data_in = 8'hA5; parity_type = 2'b10; data_length = 1'b1; stop_bits = 1'b0;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      check_frame("coinc", vecs[0].bits, 11, 16);
    end

    // tx_start held through a frame: one frame, then a second with new data
    wait_ready();
    data_in = 8'h41; parity_type = 2'b00; data_length = 1'b0; stop_bits = 1'b1;
    tx_start = 1'b1;
    @(negedge clk);
    data_in = 8'hD3; parity_type = 2'b10;
    check_frame("held1", vecs[1].bits, 10, -1);
    chk("held_fr_stable", fr_data, 8'h41);
    @(negedge clk);
    tx_start = 1'b0;
    chk("held2_fr_data", fr_data, 8'hD3);
    check_frame("held2", vecs[3].bits, 11, -1);

    // Reset during bit 4 of a frame
    wait_ready();
    data_in = 8'hA5; parity_type = 2'b10; data_length = 1'b1; stop_bits = 1'b0;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    begin
      int k = 0;
      while (tx_out !== 1'b0 && k < 64) begin
        @(negedge clk);
        k++;
      end
      chk("abort_start_seen", tx_out, 0);
    end
    repeat (4 * 16 + 3) @(negedge clk);
    chk("abort_bit4", tx_out, vecs[0].bits[4]);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_line", tx_out, 1);
    chk("abort_inactive", tx_active, 0);
    chk("abort_ready", ready, 1);
    chk("abort_no_done", done, 0);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || tx_out !== 1'b1) bad++;
    end
    chk("abort_quiet", bad, 0);

    // Fresh request after the abort
    wait_ready();
    data_in = 8'h3C; parity_type = 2'b01; data_length = 1'b1; stop_bits = 1'b0;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame("post_rst", vecs[2].bits, 11, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter FRAME_W, default 11: width of the frame accepted from the framer.
REQ-002 Parameter CNT_W, default 4: width of the bit counter.
REQ-003 Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 tx_start  input  1  request to send one character; sampled only when ready=1.
REQ-007 data_in  input  8  character; bit 7 is ignored for 7-bit data.
REQ-008 parity_type  input  2  00/11 none, 01 odd, 10 even.
REQ-009 data_length  input  1  0 = 7-bit, 1 = 8-bit.
REQ-010 stop_bits  input  1  0 = 1 stop bit, 1 = 2 stop bits.
REQ-011 baud_tick  input  1  one-cycle strobe, once per bit period, free-running.
REQ-012 frame_in  input  FRAME_W  framed character from the framer, LSB = start bit.
REQ-013 fr_data, fr_parity_type, fr_data_length, fr_stop_bits  output  8/2/1/1  registered copies of the accepted request, driven to the framer.
REQ-014 tx_active  output  1  framer enable.
REQ-015 tx_out  output  1  serial line; idles at 1.
REQ-016 ready  output  1  high only in IDLE.
REQ-017 done  output  1  one-cycle pulse after the last stop bit.
REQ-018 cfg_err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-019 States SHALL be IDLE, LOAD, ALIGN, SEND and DONE.
REQ-020 IDLE: when tx_start=1, the block SHALL register data_in and the config onto the fr_* outputs.
- If the config is legal (data_length != stop_bits), go to LOAD.
- Otherwise, pulse cfg_err for 1 cycle and stay in IDLE.
REQ-021 LOAD (1 cycle): tx_active=1; at the end of the cycle, capture frame_in into the shift register.
- Set N = 10 + parity_en, where parity_en = 1 for parity_type 01 or 10.
- Clear bit_cnt; go to ALIGN.
REQ-022 ALIGN: tx_out=1 and the block waits for baud_tick.
- On the cycle after that tick, enter SEND; tx_out = shreg[0] (start bit, 0).
REQ-023 SEND: tx_out SHALL be shreg[0], held constant between ticks.
- Each baud_tick: shift right with 1 fill, bit_cnt+1.
- On the tick where bit_cnt = N-1: go to DONE, tx_out=1.
REQ-024 Each transmitted bit SHALL last exactly one baud_tick period; N bits per frame, LSB first.
REQ-025 DONE (1 cycle): done=1, then IDLE. Minimum gap between frames is 2 cycles plus the ALIGN wait.
REQ-026 tx_active SHALL be 1 in LOAD, ALIGN and SEND, and 0 in IDLE and DONE.
REQ-027 fr_* outputs SHALL stay stable from acceptance until the next acceptance.
REQ-028 tx_start outside IDLE SHALL be ignored and not queued. baud_tick in IDLE, LOAD or DONE SHALL have no effect.
REQ-029 tx_start and baud_tick in the same IDLE cycle: the request is accepted; the tick is ignored.
REQ-030 bit_cnt SHALL never exceed N-1 and SHALL not wrap.
REQ-031 Registered outputs: tx_out, ready, done, cfg_err and tx_active are decoded from registered state only.

Reset
REQ-032 rst=1 SHALL, at the next clk edge, force IDLE, tx_out=1, tx_active=0, ready=1, done=0, cfg_err=0, bit_cnt=0, shreg all 1s and fr_* all 0.
REQ-033 rst mid-frame SHALL abort the frame with no done pulse; the line returns to 1 on the same edge.

Structure
REQ-034 Package uart_pkg SHALL hold:
- the state enum;
- parity encodings PAR_NONE, PAR_ODD, PAR_EVEN;
- FRAME_W;
- the frame-length constants 10 and 11.
REQ-035 No sub-module: the bit counter and shift register are inline. The framer is instantiated beside this block at the top level.

Verification
REQ-036 8-bit, even parity, 1 stop, data 0xA5, tick every 16 cycles:
- tx_out = 0,1,0,1,0,0,1,0,1,0,1, each held 16 cycles;
- done 1 cycle later.
REQ-037 7-bit, no parity, 2 stop, data 0x41:
- 10 bits 0,1,0,0,0,0,0,1,1,1;
- no 11th bit; done pulses once.
REQ-038 Illegal config (8-bit, 2 stop):
- cfg_err pulses 1 cycle; tx_active stays 0; tx_out stays 1; ready remains 1.
REQ-039 tx_start held high throughout a frame:
- exactly one frame sent;
- a second frame starts only after DONE, with fr_data updated to the new value.
REQ-040 rst asserted on the 5th bit of a frame:
- next edge: tx_out=1, tx_active=0, ready=1, no done;
- a new request afterwards transmits correctly.
REQ-041 tx_start coincident with baud_tick in IDLE:
- ALIGN waits for the next tick;
- start bit lasts a full tick period.
